// File: rtl/systolic_pkg.sv
// systolic_pkg: shared widths, saturation limits and accumulator FSM states
package systolic_pkg;
    localparam int ACC_W = 32;
    localparam logic [ACC_W-1:0] INT32_MAX = 32'h7FFF_FFFF;
    localparam logic [ACC_W-1:0] INT32_MIN = 32'h8000_0000;
    typedef enum logic [1:0] {IDLE, ACCUM, DRAIN} psum_acc_state_t;
endpackage

// File: rtl/sat_add32.sv
// sat_add32: combinational signed 32-bit adder that clamps to int32 and flags the clamp
module sat_add32
    import systolic_pkg::*;
(
    input  logic [ACC_W-1:0] a,
    input  logic [ACC_W-1:0] b,
    output logic [ACC_W-1:0] y,
    output logic             clamp
);
    logic [ACC_W:0] s;
    assign s     = {a[ACC_W-1], a} + {b[ACC_W-1], b};
    assign clamp = s[ACC_W] ^ s[ACC_W-1];
    assign y     = clamp ? (s[ACC_W] ? INT32_MIN : INT32_MAX) : s[ACC_W-1:0];
endmodule

// File: rtl/psum_accumulator.sv
// psum_accumulator: saturating per-column psum accumulation over K-tiles, then column-serial drain
module psum_accumulator
    import systolic_pkg::*;
#(
    parameter int COLS   = 4,
    parameter int TILE_W = 8,
    localparam int CW    = (COLS > 1) ? $clog2(COLS) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [TILE_W-1:0]    num_tiles,
    input  logic                 psum_valid,
    output logic                 psum_ready,
    input  logic [COLS*32-1:0]   psum_in,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [ACC_W-1:0]     out_data,
    output logic [CW-1:0]        out_col,
    output logic                 busy,
    output logic                 done,
    output logic                 sat_flag
);
    psum_acc_state_t state, state_n;
    logic [ACC_W-1:0]  acc [COLS];
    logic [ACC_W-1:0]  sum [COLS];
    logic [COLS-1:0]   clamp;
    logic [TILE_W-1:0] cnt, tiles;
    logic [CW-1:0]     nxt_col;
    logic [ACC_W-1:0]  nxt_data;
    logic              go, beat, last_beat, hs, last_col;

    assign psum_ready = state == ACCUM;
    assign out_valid  = state == DRAIN;
    assign busy       = state != IDLE;
    assign go         = state == IDLE && start;
    assign beat       = psum_valid && psum_ready;
    assign last_beat  = beat && cnt == tiles - 1'b1;
    assign hs         = out_valid && out_ready;
    assign last_col   = hs && out_col == CW'(COLS - 1);
    assign nxt_col    = out_col + 1'b1;

    for (genvar g = 0; g < COLS; g++) begin : g_lane
        sat_add32 u_add (.a(acc[g]), .b(psum_in[32*g +: 32]), .y(sum[g]), .clamp(clamp[g]));
    end

    // select the accumulator that becomes out_data after the current column is accepted
    always_comb begin
        nxt_data = '0;
        for (int c = 0; c < COLS; c++)
            if (CW'(c) == nxt_col) nxt_data = acc[c];
    end

    // next-state: start -> ACCUM, final beat -> DRAIN, final column -> IDLE
    always_comb begin
        state_n = state;
        state_n = go ? ACCUM : last_beat ? DRAIN : last_col ? IDLE : state;
    end

    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    // accumulators, counters, registered output column and sticky clamp flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int c = 0; c < COLS; c++) acc[c] <= '0;
            cnt      <= '0;
            tiles    <= '0;
            out_col  <= '0;
            out_data <= '0;
            sat_flag <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= last_col;
            if (go) begin
                for (int c = 0; c < COLS; c++) acc[c] <= '0;
                cnt      <= '0;
                tiles    <= (num_tiles == '0) ? TILE_W'(1) : num_tiles;
                out_col  <= '0;
                out_data <= '0;
                sat_flag <= 1'b0;
            end
            if (beat) begin
                for (int c = 0; c < COLS; c++) acc[c] <= sum[c];
                cnt <= cnt + 1'b1;
                if (|clamp) sat_flag <= 1'b1;
                if (last_beat) out_data <= sum[0];
            end
            if (hs && !last_col) begin
                out_col  <= nxt_col;
                out_data <= nxt_data;
            end
        end
    end
endmodule

// File: tb/tb_psum_accumulator.sv
// tb_psum_accumulator: randomized scoreboard bench against an arithmetic reference model
module tb_psum_accumulator;
    localparam int COLS = 4;
    localparam int TILE_W = 8;
    localparam int CW = 2;

    logic clk = 0, rst = 1, start = 0, psum_valid = 0, out_ready = 0;
    logic [TILE_W-1:0] num_tiles = '0;
    logic [COLS*32-1:0] psum_in = '0;
    logic psum_ready, out_valid, busy, done, sat_flag;
    logic [31:0] out_data;
    logic [CW-1:0] out_col;

    int checks = 0, errors = 0;
    logic [31:0] beat_mem [16][COLS];
    int exp_col [$];
    logic [31:0] exp_data [$];
    bit have_prev = 0;
    logic [31:0] prev_data;
    logic [CW-1:0] prev_col;

    psum_accumulator #(.COLS(COLS), .TILE_W(TILE_W)) dut (
        .clk(clk), .rst(rst), .start(start), .num_tiles(num_tiles),
        .psum_valid(psum_valid), .psum_ready(psum_ready), .psum_in(psum_in),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_col(out_col), .busy(busy), .done(done), .sat_flag(sat_flag)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // monitor: pop expected columns on each handshake, verify stability under back-pressure
    always @(negedge clk) begin
        if (rst) have_prev = 0;
        else begin
            if (have_prev) begin
                chk("bp_hold_data", out_data, prev_data);
                chk("bp_hold_col", 32'(out_col), 32'(prev_col));
            end
            have_prev = out_valid && !out_ready;
            prev_data = out_data;
            prev_col = out_col;
            if (out_valid && out_ready) begin
                if (exp_data.size() == 0) chk("unexpected_output", 32'(out_col), 32'hFFFF_FFFF);
                else begin
                    chk("out_col", 32'(out_col), 32'(exp_col.pop_front()));
                    chk("out_data", out_data, exp_data.pop_front());
                end
            end
        end
    end

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_psum_ready"}, 32'(psum_ready), 0);
        chk({tag, "_out_valid"}, 32'(out_valid), 0);
        chk({tag, "_out_data"}, out_data, 0);
        chk({tag, "_out_col"}, 32'(out_col), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_done"}, 32'(done), 0);
        chk({tag, "_sat_flag"}, 32'(sat_flag), 0);
    endtask

    // mode: 0 ready always, 1 random ready, 2 stall column 2 for 5 cycles, 3 stray start in drain
    task automatic job(input int nt, input int mode);
        int nb, b, cyc, stall;
        bit esat, got, acc_ok;
        logic [31:0] e [COLS];
        nb = (nt == 0) ? 1 : nt;
        esat = 0;
        for (int c = 0; c < COLS; c++) e[c] = 0;
        for (int i = 0; i < nb; i++)
            for (int c = 0; c < COLS; c++) begin
                longint s;
                s = longint'($signed(e[c])) + longint'($signed(beat_mem[i][c]));
                if (s > 64'sd2147483647) begin s = 64'sd2147483647; esat = 1; end
                else if (s < -64'sd2147483648) begin s = -64'sd2147483648; esat = 1; end
                e[c] = s[31:0];
            end
        for (int c = 0; c < COLS; c++) begin
            exp_col.push_back(c);
            exp_data.push_back(e[c]);
        end
        @(posedge clk); #1;
        start = 1;
        num_tiles = TILE_W'(nt);
        out_ready = (mode == 0);
        @(posedge clk); #1;
        start = 0;
        chk("ready_after_start", 32'(psum_ready), 1);
        chk("busy_after_start", 32'(busy), 1);
        chk("sat_cleared_on_start", 32'(sat_flag), 0);
        b = 0;
        cyc = 0;
        while (b < nb && cyc < 300) begin
            psum_valid = ($urandom_range(0, 3) != 0);
            for (int c = 0; c < COLS; c++) psum_in[32*c +: 32] = psum_valid ? beat_mem[b][c] : $urandom;
            acc_ok = psum_valid && psum_ready;
            @(posedge clk); #1;
            if (acc_ok) b++;
            cyc++;
        end
        psum_valid = 0;
        chk("beats_accepted", b, nb);
        chk("out_valid_after_last", 32'(out_valid), 1);
        chk("ready_low_after_last", 32'(psum_ready), 0);
        cyc = 0;
        stall = 0;
        got = 0;
        while (!got && cyc < 300) begin
            if (mode == 1) out_ready = $urandom_range(0, 1);
            else if (mode == 2 && out_valid && out_col == 2 && stall < 5) begin out_ready = 0; stall++; end
            else out_ready = 1;
            start = (mode == 3 && cyc == 0);
            num_tiles = 9;
            @(posedge clk); #1;
            cyc++;
            got = done;
        end
        start = 0;
        chk("done_seen", 32'(got), 1);
        if (mode == 0) chk("drain_cycles", cyc, COLS);
        if (mode == 2) chk("stall_cycles", stall, 5);
        chk("busy_after_done", 32'(busy), 0);
        chk("sat_flag", 32'(sat_flag), 32'(esat));
        chk("queue_drained", exp_data.size(), 0);
        @(posedge clk); #1;
        chk("done_one_cycle", 32'(done), 0);
        chk("sat_sticky", 32'(sat_flag), 32'(esat));
    endtask

    function automatic logic [31:0] rnd_val();
        int k;
        k = $urandom_range(0, 3);
        return (k == 0) ? (32'h7FFF_FF00 | 32'($urandom_range(0, 255)))
             : (k == 1) ? (32'h8000_0000 | 32'($urandom_range(0, 255)))
             : 32'($signed($urandom_range(0, 2000)) - 1000);
    endfunction

    task automatic clear_mem();
        for (int i = 0; i < 16; i++)
            for (int c = 0; c < COLS; c++) beat_mem[i][c] = 0;
    endtask

    initial begin
        #3;
        check_idle_outputs("reset");
        @(posedge clk); #1;
        rst = 0;
        for (int i = 0; i < 3; i++) begin
            psum_valid = 1;
            psum_in = {$urandom, $urandom, $urandom, $urandom};
            out_ready = 1;
            @(posedge clk); #1;
        end
        psum_valid = 0;
        check_idle_outputs("stray_idle");

        clear_mem();
        for (int i = 0; i < 3; i++)
            for (int c = 0; c < COLS; c++) beat_mem[i][c] = 32'((i + 1) * 10 * (c + 1));
        job(3, 0);

        clear_mem();
        beat_mem[0][0] = 32'h7FFF_FFF0;
        beat_mem[1][0] = 32'h0000_0100;
        job(2, 0);

        clear_mem();
        beat_mem[0][1] = 32'h8000_0000;
        beat_mem[1][1] = 32'hFFFF_FFFF;
        job(2, 1);

        clear_mem();
        for (int i = 0; i < 4; i++)
            for (int c = 0; c < COLS; c++) beat_mem[i][c] = $urandom_range(0, 5000);
        job(4, 2);

        clear_mem();
        for (int c = 0; c < COLS; c++) beat_mem[0][c] = 7;
        job(0, 3);

        clear_mem();
        beat_mem[0][2] = 32'h7FFF_FFFF;
        beat_mem[1][2] = 32'h7FFF_FFFF;
        @(posedge clk); #1;
        start = 1;
        num_tiles = 3;
        @(posedge clk); #1;
        start = 0;
        psum_valid = 1;
        for (int c = 0; c < COLS; c++) psum_in[32*c +: 32] = 32'h7FFF_FFFF;
        @(posedge clk); #1;
        psum_valid = 0;
        chk("midjob_busy", 32'(busy), 1);
        #2 rst = 1;
        #1;
        check_idle_outputs("midjob_reset");
        @(posedge clk); #1;
        rst = 0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("no_done_after_reset", 32'(done), 0);
        end
        chk("idle_after_reset", 32'(busy), 0);

        for (int j = 0; j < 20; j++) begin
            int nt;
            nt = $urandom_range(0, 6);
            for (int i = 0; i < 16; i++)
                for (int c = 0; c < COLS; c++) beat_mem[i][c] = rnd_val();
            job(nt, $urandom_range(0, 2));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end
endmodule
